// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: NRD-read / 2-write integer register file with busy-bit scoreboard, x0 hardwired to zero.
// Latency: reads and hazard flags are combinational; writes and busy bits update at posedge. No backpressure, issue_busy is advisory.
// Optional REGFILE_BYPASS_EN: same-cycle writeback data and busy-clear are forwarded onto the read ports.
module regfile_mp_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       wa0,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd0,
  input  logic [XLEN-1:0]     wd1,
  input  logic                issue_vld,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_busy,
  input  logic                flush
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // Entry 0 is never written, so x0 stays zero; addresses >= NREGS match no entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (we1 && wa1 == AW'(r))
          regs[r] <= wd1;
        else if (we0 && wa0 == AW'(r))
          regs[r] <= wd0;
      end
    end
  end

  // A new producer outranks a writeback clear; flush outranks everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (flush)
          busy[r] <= 1'b0;
        else if (issue_vld && issue_rd == AW'(r))
          busy[r] <= 1'b1;
        else if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r)))
          busy[r] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (ra[k*AW +: AW] == AW'(r)) begin
          rdata[k*XLEN +: XLEN] = regs[r];
          rbusy[k]              = busy[r];
`ifdef REGFILE_BYPASS_EN
          if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r))) begin
            rdata[k*XLEN +: XLEN] = (we1 && wa1 == AW'(r)) ? wd1 : wd0;
            rbusy[k]              = issue_vld && issue_rd == AW'(r);
          end
`endif
        end
      end
    end
  end

  always_comb begin
    issue_busy = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (issue_vld && issue_rd == AW'(r)) issue_busy = busy[r];
    end
  end

endmodule
